axil_reg_slave: RTL

//  Parametrised AXI4-Lite slave register file, the synthesizable endpoint behind the glc AXI-lite port.

---
 rtl/axil_pkg.sv | 14 +
 rtl/axil_hold_slot.sv | 48 ++++
 rtl/axil_reg_slave.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite response codes and channel widths for the register slave.
package axil_pkg;

    localparam int AXIL_PROT_W = 3;
    localparam int AXIL_RESP_W = 2;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axil_resp_e;

endpackage

// File: rtl/axil_hold_slot.sv
// One-entry capture register for an AXI-Lite request channel.
// full_o/data_o also reflect a beat being accepted this cycle, so a commit can use it on the same edge.
module axil_hold_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_i,
    input  logic         block_i,
    input  logic [W-1:0] data_i,
    input  logic         clear_i,
    output logic         ready_o,
    output logic         full_o,
    output logic [W-1:0] data_o
);

    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;
    logic         fire;

    assign ready_o = !full_q && !block_i;
    assign fire    = valid_i && ready_o;
    assign full_o  = full_q || fire;
    assign data_o  = full_q ? data_q : data_i;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (fire) begin
            full_d = 1'b1;
            data_d = data_i;
        end
        if (clear_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register file slave with byte strobes, DECERR/SLVERR responses,
// per-register write pulses and hardware load ports.
module axil_reg_slave
    import axil_pkg::*;
#(
    parameter int                  AXI_DWIDTH = 32,
    parameter int                  AXI_AWIDTH = 12,
    parameter int                  NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [AXI_AWIDTH-1:0]          AWADDR,
    input  logic                           AWVALID,
    input  logic [AXIL_PROT_W-1:0]         AWPROT,
    output logic                           AWREADY,
    input  logic [AXI_DWIDTH-1:0]          WDATA,
    input  logic [AXI_DWIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic                           BVALID,
    output logic [AXIL_RESP_W-1:0]         BRESP,
    input  logic                           BREADY,
    input  logic [AXI_AWIDTH-1:0]          ARADDR,
    input  logic                           ARVALID,
    input  logic [AXIL_PROT_W-1:0]         ARPROT,
    output logic                           ARREADY,
    output logic [AXI_DWIDTH-1:0]          RDATA,
    output logic [AXIL_RESP_W-1:0]         RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS*AXI_DWIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse,
    input  logic [NUM_REGS-1:0]            hw_wr_en,
    input  logic [NUM_REGS*AXI_DWIDTH-1:0] hw_wr_data
);

    localparam int SW        = AXI_DWIDTH / 8;
    localparam int LANE_BITS = $clog2(SW);

    logic                  aw_have, w_have, commit;
    logic [AXI_AWIDTH-1:0] aw_addr, widx, ridx;
    logic [AXI_DWIDTH+SW-1:0] w_bus;
    logic                  w_mapped, w_ro, r_mapped, ar_fire;
    logic [NUM_REGS-1:0]   sw_we;
    logic [AXI_DWIDTH-1:0] rd_word;

    logic                  bvalid_q, bvalid_d;
    axil_resp_e            bresp_q, bresp_d;
    logic [NUM_REGS-1:0]   wr_pulse_q;
    logic                  rvalid_q, rvalid_d;
    axil_resp_e            rresp_q, rresp_d;
    logic [AXI_DWIDTH-1:0] rdata_q, rdata_d;

    logic unused_prot;
    assign unused_prot = ^{AWPROT, ARPROT};

    axil_hold_slot #(.W(AXI_AWIDTH)) u_aw_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (AWVALID),
        .block_i (bvalid_q),
        .data_i  (AWADDR),
        .clear_i (commit),
        .ready_o (AWREADY),
        .full_o  (aw_have),
        .data_o  (aw_addr)
    );

    axil_hold_slot #(.W(AXI_DWIDTH + SW)) u_w_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (WVALID),
        .block_i (bvalid_q),
        .data_i  ({WSTRB, WDATA}),
        .clear_i (commit),
        .ready_o (WREADY),
        .full_o  (w_have),
        .data_o  (w_bus)
    );

    assign commit   = aw_have && w_have;
    assign widx     = aw_addr >> LANE_BITS;
    assign w_mapped = widx < AXI_AWIDTH'(NUM_REGS);

    // RO registers never see a software enable, so a hardware load still lands on them
    always_comb begin
        w_ro  = 1'b0;
        sw_we = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (widx == AXI_AWIDTH'(i)) begin
                w_ro     = RO_MASK[i];
                sw_we[i] = commit && !RO_MASK[i];
            end
        end
    end

    always_comb begin
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = !w_mapped ? DECERR : (w_ro ? SLVERR : OKAY);
        end else if (bvalid_q && BREADY) begin
            bvalid_d = 1'b0;
        end
    end

    assign ARREADY  = !rvalid_q || RREADY;
    assign ar_fire  = ARVALID && ARREADY;
    assign ridx     = ARADDR >> LANE_BITS;
    assign r_mapped = ridx < AXI_AWIDTH'(NUM_REGS);

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ridx == AXI_AWIDTH'(i)) begin
                rd_word = reg_q[i*AXI_DWIDTH +: AXI_DWIDTH];
            end
        end
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        if (ar_fire) begin
            rvalid_d = 1'b1;
            rresp_d  = r_mapped ? OKAY : DECERR;
            rdata_d  = rd_word;
        end else if (RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bvalid_q   <= 1'b0;
            bresp_q    <= OKAY;
            wr_pulse_q <= '0;
            rvalid_q   <= 1'b0;
            rresp_q    <= OKAY;
            rdata_q    <= '0;
        end else begin
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= sw_we;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

    assign BVALID   = bvalid_q;
    assign BRESP    = bresp_q;
    assign wr_pulse = wr_pulse_q;
    assign RVALID   = rvalid_q;
    assign RRESP    = rresp_q;
    assign RDATA    = rdata_q;

    function automatic logic [AXI_DWIDTH-1:0] merge_bytes(
        input logic [AXI_DWIDTH-1:0] old_w,
        input logic [AXI_DWIDTH-1:0] new_w,
        input logic [SW-1:0]         strb
    );
        logic [AXI_DWIDTH-1:0] res;
        res = old_w;
        for (int j = 0; j < SW; j++) begin
            if (strb[j]) res[j*8 +: 8] = new_w[j*8 +: 8];
        end
        return res;
    endfunction

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        logic [AXI_DWIDTH-1:0] r_q;

        // Software beats hardware when both hit the same register on one edge
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_q <= '0;
            end else if (sw_we[gi]) begin
                r_q <= merge_bytes(r_q, w_bus[AXI_DWIDTH-1:0], w_bus[AXI_DWIDTH +: SW]);
            end else if (hw_wr_en[gi]) begin
                r_q <= hw_wr_data[gi*AXI_DWIDTH +: AXI_DWIDTH];
            end
        end

        assign reg_q[gi*AXI_DWIDTH +: AXI_DWIDTH] = r_q;
    end

endmodule
